pixie_dma_sched: RTL and testbench

PIXIE_DMA_SCHED -- requirements
Module: pixie_dma_sched

---
 rtl/pixie_dma_sched_pkg.sv | 24 ++
 rtl/pixie_dma_sched_if.sv | 24 ++
 rtl/pixie_dma_sched_line_buf.sv | 43 ++++
 rtl/pixie_dma_sched.sv | 110 +++++++++++
 tb/tb_pixie_dma_sched.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/pixie_dma_sched_pkg.sv
// Shared constants and helpers for the Pixie (CDP1861-style) DMA scheduler.
package pixie_pkg;

    localparam logic [3:0] LINE_CYCLES = 4'd14;
    localparam logic [8:0] NTSC_LINES  = 9'd262;
    localparam logic [8:0] PAL_LINES   = 9'd312;
    localparam logic [8:0] DS_NTSC     = 9'd80;
    localparam logic [8:0] DS_PAL      = 9'd104;
    localparam logic [8:0] DISP_ROWS   = 9'd128;
    localparam logic [3:0] LINE_BYTES  = 4'd8;
    localparam logic [3:0] DMA_FIRST   = 4'd2;
    localparam logic [3:0] DMA_LAST    = 4'd12;

    typedef logic [7:0] byte_t;
    typedef logic [3:0] cyc_t;
    typedef logic [8:0] line_t;
    typedef logic [3:0] slot_t;

    // True when v lies in the half-open window [lo, lo+n).
    function automatic logic in_range(line_t v, line_t lo, line_t n);
        return (v >= lo) && (v < lo + n);
    endfunction

endpackage

// File: rtl/pixie_dma_sched_if.sv
// CPU DMA/interrupt handshake plus completed-line output bus of the scheduler.
interface pixie_dma_sched_if;
    import pixie_pkg::*;

    logic        dma_req;
    logic        dma_ack;
    byte_t       dma_data;
    logic        int_req;
    logic        ef1;
    logic        lb_valid;
    logic [63:0] lb_data;
    logic [6:0]  lb_row;

    modport master (
        output dma_req, int_req, ef1, lb_valid, lb_data, lb_row,
        input  dma_ack, dma_data
    );

    modport slave (
        input  dma_req, int_req, ef1, lb_valid, lb_data, lb_row,
        output dma_ack, dma_data
    );

endinterface

// File: rtl/pixie_dma_sched_line_buf.sv
// 8x8 line buffer: sequential byte writes by slot index, bulk clear, 64-bit parallel read.
module pixie_line_buf
    import pixie_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        wr_en,
    input  byte_t       wr_data,
    output slot_t       slot,
    output logic [63:0] rd_data
);

    slot_t slot_reg;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            slot_reg <= '0;
        end else if (wr_en && (slot_reg < LINE_BYTES)) begin
            slot_reg <= slot_reg + 4'd1;
        end
    end

    assign slot = slot_reg;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_byte
            byte_t byte_reg;

            always_ff @(posedge clk) begin
                if (reset || clr) begin
                    byte_reg <= '0;
                end else if (wr_en && (slot_reg == 4'(gi))) begin
                    byte_reg <= wr_data;
                end
            end

            // Slot 0 lands in the top byte so the leftmost pixel is the MSB.
            assign rd_data[63 - 8*gi -: 8] = byte_reg;
        end
    endgenerate

endmodule

// File: rtl/pixie_dma_sched.sv
// Pixie video DMA scheduler: line/frame timing, display DMA window, line capture.
// Optional macro PIXIE_PAL_EN enables the pal input (312-line frames, DS=104).
module pixie_dma_sched
    import pixie_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic ce,
    input  logic pal,
    input  logic disp_on,
    input  logic disp_off,
    pixie_dma_sched_if.master bus,
    output logic frame_start,
    output logic underrun
);

    cyc_t  cyc_reg;
    line_t line_reg;
    logic  enable_reg;
    logic  active_reg;
    logic  underrun_reg;
    line_t frame_last;
    line_t ds;
    slot_t slot;
    logic  dma_win;
    logic  lb_fire;
    logic  line_end;
    logic  frame_end;
    logic [63:0] buf_data;

`ifdef PIXIE_PAL_EN
    logic pal_reg;

    // Frame standard only changes at the frame boundary.
    always_ff @(posedge clk) begin
        if (reset) begin
            pal_reg <= 1'b0;
        end else if (ce && frame_end) begin
            pal_reg <= pal;
        end
    end

    assign frame_last = pal_reg ? (PAL_LINES - 9'd1) : (NTSC_LINES - 9'd1);
    assign ds         = pal_reg ? DS_PAL : DS_NTSC;
`else
    logic unused_pal;
    assign unused_pal = pal;
    assign frame_last = NTSC_LINES - 9'd1;
    assign ds         = DS_NTSC;
`endif

    assign line_end  = (cyc_reg == LINE_CYCLES - 4'd1);
    assign frame_end = line_end && (line_reg == frame_last);
    assign dma_win   = active_reg && (cyc_reg >= DMA_FIRST) && (cyc_reg < DMA_LAST)
                       && (slot < LINE_BYTES);
    assign lb_fire   = ce && active_reg && line_end;

    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_reg      <= '0;
            line_reg     <= '0;
            enable_reg   <= 1'b0;
            active_reg   <= 1'b0;
            underrun_reg <= 1'b0;
        end else begin
            if (disp_off) begin
                enable_reg <= 1'b0;
            end else if (disp_on) begin
                enable_reg <= 1'b1;
            end
            if (ce) begin
                if (line_end) begin
                    cyc_reg  <= '0;
                    line_reg <= frame_end ? 9'd0 : line_reg + 9'd1;
                end else begin
                    cyc_reg <= cyc_reg + 4'd1;
                end
                // The whole line runs on the enable sampled during its cycle 0.
                if (cyc_reg == 4'd0) begin
                    active_reg <= enable_reg && in_range(line_reg, ds, DISP_ROWS);
                end
                if (lb_fire && (slot < LINE_BYTES)) begin
                    underrun_reg <= 1'b1;
                end
            end
        end
    end

    pixie_line_buf u_line_buf (
        .clk     (clk),
        .reset   (reset),
        .clr     (ce && (cyc_reg == 4'd0)),
        .wr_en   (ce && bus.dma_ack && dma_win),
        .wr_data (bus.dma_data),
        .slot    (slot),
        .rd_data (buf_data)
    );

    // Outputs are forced low while reset is held so a mid-DMA reset drops dma_req at once.
    assign bus.dma_req  = dma_win && !reset;
    assign bus.int_req  = enable_reg && in_range(line_reg, ds - 9'd2, 9'd2) && !reset;
    assign bus.ef1      = (in_range(line_reg, ds - 9'd4, 9'd4)
                           || in_range(line_reg, ds + 9'd124, 9'd4)) && !reset;
    assign bus.lb_valid = lb_fire && !reset;
    assign bus.lb_data  = reset ? 64'd0 : buf_data;
    assign bus.lb_row   = reset ? 7'd0 : 7'(line_reg - ds);
    assign frame_start  = ce && frame_end && !reset;
    assign underrun     = underrun_reg && !reset;

endmodule

// File: tb/tb_pixie_dma_sched.sv
// Randomized self-checking bench for pixie_dma_sched against a machine-cycle position model.
module tb_pixie_dma_sched;

    logic clk = 1'b0;
    logic reset, ce, pal, disp_on, disp_off;
    logic frame_start, underrun;

    pixie_dma_sched_if bus();

    pixie_dma_sched dut (
        .clk         (clk),
        .reset       (reset),
        .ce          (ce),
        .pal         (pal),
        .disp_on     (disp_on),
        .disp_off    (disp_off),
        .bus         (bus),
        .frame_start (frame_start),
        .underrun    (underrun)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: position inside the frame in machine cycles, plus line bookkeeping.
    int         m_pos;
    int         m_flen;
    bit         m_en, m_act, m_und;
    int         m_nacks;
    logic [7:0] m_bytes [8];
    int         ack_pct;
    bit         rand_pulses;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (line %0d cyc %0d)", tag, got, exp,
                     m_pos / 14, m_pos % 14);
        end
    endtask

    task automatic model_reset();
        m_pos = 0; m_flen = 262; m_en = 0; m_act = 0; m_und = 0; m_nacks = 0;
        for (int k = 0; k < 8; k++) m_bytes[k] = 8'h00;
    endtask

    // One machine cycle: ce high for one clk, then one idle clk.
    task automatic mc(input bit ack, input logic [7:0] data, input bit on, input bit off);
        int c, l, ds;
        bit e_req, e_int, e_ef1, e_lbv, e_fs;
        logic [63:0] e_data;
        @(negedge clk);
        ce = 1; bus.dma_ack = ack; bus.dma_data = data; disp_on = on; disp_off = off;
        #2;
        c  = m_pos % 14;
        l  = m_pos / 14;
        ds = (m_flen == 312) ? 104 : 80;
        if (c == 0) begin
            m_act = m_en && (l >= ds) && (l < ds + 128);
            m_nacks = 0;
            for (int k = 0; k < 8; k++) m_bytes[k] = 8'h00;
        end
        e_req = m_act && (c >= 2) && (c < 12) && (m_nacks < 8);
        e_int = m_en && (l == ds - 2 || l == ds - 1);
        e_ef1 = (l >= ds - 4 && l < ds) || (l >= ds + 124 && l < ds + 128);
        e_lbv = m_act && (c == 13);
        e_fs  = (c == 13) && (l == m_flen - 1);
        check("dma_req",     64'(bus.dma_req),  64'(e_req));
        check("int_req",     64'(bus.int_req),  64'(e_int));
        check("ef1",         64'(bus.ef1),      64'(e_ef1));
        check("lb_valid",    64'(bus.lb_valid), 64'(e_lbv));
        check("frame_start", 64'(frame_start),  64'(e_fs));
        check("underrun",    64'(underrun),     64'(m_und));
        if (e_lbv) begin
            e_data = '0;
            for (int k = 0; k < 8; k++) e_data[63 - 8*k -: 8] = m_bytes[k];
            check("lb_data", bus.lb_data, e_data);
            check("lb_row",  64'(bus.lb_row), 64'(l - ds));
            $display("[TB] line %0d row %0d data %016h acks %0d", l, bus.lb_row, bus.lb_data, m_nacks);
        end
        if (ack && e_req) begin
            m_bytes[m_nacks] = data;
            m_nacks++;
        end
        if (e_lbv && m_nacks < 8) m_und = 1;
        if (off) m_en = 0;
        else if (on) m_en = 1;
        m_pos++;
        if (m_pos == m_flen * 14) begin
            m_pos = 0;
`ifdef PIXIE_PAL_EN
            m_flen = pal ? 312 : 262;
`else
            m_flen = 262;
`endif
        end
        @(negedge clk);
        ce = 0; bus.dma_ack = 0; disp_on = 0; disp_off = 0;
        #2;
        check("idle_lb_valid",    64'(bus.lb_valid), 64'd0);
        check("idle_frame_start", 64'(frame_start),  64'd0);
    endtask

    task automatic mc_rand();
        bit on, off;
        on  = rand_pulses && ($urandom_range(0, 299) == 0);
        off = rand_pulses && ($urandom_range(0, 299) == 0);
        mc($urandom_range(0, 99) < ack_pct, 8'($urandom), on, off);
    endtask

    task automatic run_to(input int line, input int cyc);
        int budget;
        budget = 6000;
        while (m_pos != line * 14 + cyc) begin
            if (budget == 0) begin
                check("run_to_timeout", 64'd1, 64'd0);
                return;
            end
            budget--;
            if (m_pos % 14 == 0) begin
                case ($urandom_range(0, 3))
                    0: ack_pct = 100;
                    1: ack_pct = 90;
                    2: ack_pct = 60;
                    default: ack_pct = 10;
                endcase
            end
            mc_rand();
        end
    endtask

    task automatic check_all_low(input string tag);
        check({tag, "_dma_req"},     64'(bus.dma_req),  64'd0);
        check({tag, "_int_req"},     64'(bus.int_req),  64'd0);
        check({tag, "_ef1"},         64'(bus.ef1),      64'd0);
        check({tag, "_lb_valid"},    64'(bus.lb_valid), 64'd0);
        check({tag, "_frame_start"}, 64'(frame_start),  64'd0);
        check({tag, "_underrun"},    64'(underrun),     64'd0);
    endtask

    initial begin
        reset = 1; ce = 0; pal = 0; disp_on = 0; disp_off = 0;
        bus.dma_ack = 0; bus.dma_data = 8'h00;
        ack_pct = 0; rand_pulses = 0;
        model_reset();
        repeat (3) @(negedge clk);
        #2 check_all_low("in_reset");
        @(negedge clk);
        reset = 0;
        #2 check_all_low("post_reset");

        // Frame A: enable, full line 80, short line 81, then random lines.
        mc(0, 8'h00, 1, 0);
        run_to(80, 0);
        for (int c = 0; c < 14; c++) mc(c >= 2 && c <= 9, 8'(c - 1), 0, 0);
        for (int c = 0; c < 14; c++) mc(c >= 2 && c <= 6, 8'($urandom), 0, 0);
        run_to(0, 0);

        // Frame B: simultaneous on/off leaves display disabled, re-enable mid-display.
        run_to(70, 0);
        mc(0, 8'h00, 1, 1);
        run_to(100, 5);
        mc(0, 8'h00, 1, 0);
        run_to(0, 0);

        // Reset in the middle of a DMA window.
        run_to(82, 0);
        for (int c = 0; c < 5; c++) mc(0, 8'h00, 0, 0);
        @(negedge clk);
        reset = 1;
        #2 check("rst_dma_req_same_clk", 64'(bus.dma_req), 64'd0);
        @(negedge clk);
        reset = 0;
        model_reset();
        #2 check_all_low("after_mid_reset");
        mc(0, 8'h00, 1, 0);
        run_to(80, 4);

        // pal raised mid-frame: current frame stays NTSC, next one follows pal.
        run_to(150, 0);
        pal = 1;
        run_to(0, 0);
        run_to(110, 0);
        run_to(0, 0);

        // Random enable/disable traffic.
        pal = 0;
        rand_pulses = 1;
        run_to(0, 3);
        run_to(200, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
